// File: rtl/bcd_seg_display_mux.sv
// Two-digit BCD display multiplexer: handshake capture into a shadow register,
// frame-aligned commit, and a time-multiplexed registered 7-segment drive.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks a zero tens digit).
module bcd_seg_display_mux #(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  input  logic       bcd_valid,
  output logic       bcd_ready,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       err
);

  localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic {
    ONES = 1'b0,
    TENS = 1'b1
  } slot_t;

  slot_t            slot;
  slot_t            slot_next;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             frame_edge;
  logic             accept;
  logic [7:0]       shadow;
  logic [7:0]       disp;
  logic             pending;
  logic [3:0]       nib;
  logic [6:0]       seg_raw;
  logic [6:0]       seg_next;
  logic [1:0]       dig_next;
  logic             err_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign wrap       = (cnt == CNT_MAX);
  assign frame_edge = wrap && (slot == TENS);
  assign accept     = bcd_valid && !pending;
  assign bcd_ready  = !pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= ONES;
    end else begin
      slot <= slot_next;
    end
  end

  always_comb begin
    slot_next = slot;
    case (slot)
      ONES:    if (wrap) slot_next = TENS;
      TENS:    if (wrap) slot_next = ONES;
      default: slot_next = ONES;
    endcase
  end

  // Commit and accept are mutually exclusive because ready is low while pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= 8'h00;
      disp    <= 8'h00;
      pending <= 1'b0;
    end else if (frame_edge && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= bcd_in;
      pending <= 1'b1;
    end
  end

  always_comb begin
    nib      = (slot == TENS) ? disp[7:4] : disp[3:0];
    seg_raw  = decode(nib);
`ifdef LEADING_ZERO_BLANK_EN
    if ((slot == TENS) && (disp[7:4] == 4'd0)) begin
      seg_raw = 7'h00;
    end
`endif
    seg_next = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_next = (slot == TENS) ? 2'b10 : 2'b01;
    err_next = (disp[7:4] > 4'd9) || (disp[3:0] > 4'd9);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= SEG_OFF;
      dig_en <= 2'b00;
      err    <= 1'b0;
    end else begin
      seg    <= seg_next;
      dig_en <= dig_next;
      err    <= err_next;
    end
  end

endmodule

// File: tb/tb_bcd_seg_display_mux.sv
// Randomized self-checking bench for bcd_seg_display_mux against a cycle-count
// based reference model of the frame schedule and commit rules.
module tb_bcd_seg_display_mux;

  localparam int R = 4;

  logic       clk;
  logic       rst;
  logic [7:0] bcd_in;
  logic       bcd_valid;
  logic       bcd_ready;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       err;

  int n_checks;
  int n_fail;

  // Reference model state
  int         cyc;
  logic [7:0] m_shadow;
  logic [7:0] m_disp;
  logic       m_pend;
  logic       m_acc;
  logic [6:0] exp_seg;
  logic [1:0] exp_dig;
  logic       exp_err;
  logic [6:0] seg_tab [16];

  bcd_seg_display_mux #(
    .REFRESH_DIV   (R),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .bcd_valid(bcd_valid),
    .bcd_ready(bcd_ready),
    .seg      (seg),
    .dig_en   (dig_en),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    cyc      = 0;
    m_shadow = 8'h00;
    m_disp   = 8'h00;
    m_pend   = 1'b0;
    m_acc    = 1'b0;
    exp_seg  = 7'h00;
    exp_dig  = 2'b00;
    exp_err  = 1'b0;
  endtask

  // Advance one clock edge; the model sees the slot as a function of elapsed cycles.
  task automatic tick();
    logic       tens;
    logic       boundary;
    logic [3:0] n;
    @(posedge clk);
    m_acc = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      tens     = ((cyc / R) % 2) == 1;
      boundary = (cyc % (2 * R)) == (2 * R - 1);
      n        = tens ? m_disp[7:4] : m_disp[3:0];
      exp_dig  = tens ? 2'b10 : 2'b01;
      exp_seg  = seg_tab[n];
`ifdef LEADING_ZERO_BLANK_EN
      if (tens && m_disp[7:4] == 4'd0) exp_seg = 7'h00;
`endif
      exp_err  = (m_disp[7:4] > 4'd9) || (m_disp[3:0] > 4'd9);
      if (boundary && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (bcd_valid && !m_pend) begin
        m_shadow = bcd_in;
        m_pend   = 1'b1;
        m_acc    = 1'b1;
      end
      cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bcd_in    = 8'h00;
    bcd_valid = 1'b0;
    model_reset();
    repeat (2) tick();
    n_checks++;
    if (seg !== 7'h00) begin n_fail++; $display("[TB] FAIL reset_seg got=%h exp=%h", seg, 7'h00); end
    n_checks++;
    if (dig_en !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_dig got=%b exp=%b", dig_en, 2'b00); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    n_checks++;
    if (bcd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got=%b exp=1", bcd_ready); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (dig_en !== 2'b01 || seg !== 7'h3F) begin
      n_fail++; $display("[TB] FAIL first_slot got=%b/%h exp=01/3f", dig_en, seg);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (seg !== exp_seg || dig_en !== exp_dig || err !== exp_err || bcd_ready !== !m_pend) begin
        n_fail++;
        $display("[TB] FAIL reset_run cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, seg, dig_en, err, bcd_ready, exp_seg, exp_dig, exp_err, !m_pend);
      end
    end
  endtask

  task automatic test_accept();
    bit saw_ones, saw_tens, saw_ready_low;
    saw_ones = 0; saw_tens = 0; saw_ready_low = 0;
    bcd_in = 8'h27; bcd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_acc) bcd_valid = 1'b0;
      if (!bcd_ready) saw_ready_low = 1;
      if (dig_en == 2'b01 && seg == 7'h07) saw_ones = 1;
      if (dig_en == 2'b10 && seg == 7'h5B) saw_tens = 1;
      n_checks++;
      if (seg !== exp_seg || dig_en !== exp_dig || err !== exp_err || bcd_ready !== !m_pend) begin
        n_fail++;
        $display("[TB] FAIL accept cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, seg, dig_en, err, bcd_ready, exp_seg, exp_dig, exp_err, !m_pend);
      end
    end
    n_checks++;
    if (bcd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL accept_timeout got=valid_high exp=accepted"); bcd_valid = 1'b0; end
    n_checks++;
    if ({saw_ready_low, saw_ones, saw_tens} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL accept_digits got=%b exp=111", {saw_ready_low, saw_ones, saw_tens});
    end
  endtask

  task automatic test_back_to_back();
    bit saw_3, saw_1;
    int stage;
    saw_3 = 0; saw_1 = 0; stage = 0;
    bcd_in = 8'h27; bcd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (m_acc) begin
        if (stage == 0) begin bcd_in = 8'h31; stage = 1; end
        else begin bcd_valid = 1'b0; stage = 2; end
      end
      if (dig_en == 2'b10 && seg == 7'h4F) saw_3 = 1;
      if (dig_en == 2'b01 && seg == 7'h06) saw_1 = 1;
      n_checks++;
      if (seg !== exp_seg || dig_en !== exp_dig || err !== exp_err || bcd_ready !== !m_pend) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, seg, dig_en, err, bcd_ready, exp_seg, exp_dig, exp_err, !m_pend);
      end
    end
    bcd_valid = 1'b0;
    n_checks++;
    if (stage != 2 || !saw_3 || !saw_1) begin
      n_fail++; $display("[TB] FAIL back_to_back_seq got=stage%0d/%0d%0d exp=stage2/11", stage, saw_3, saw_1);
    end
  endtask

  task automatic test_invalid();
    bit saw_err, saw_dash, saw_clear;
    logic [7:0] words [2];
    saw_err = 0; saw_dash = 0; saw_clear = 0;
    words[0] = 8'h1A; words[1] = 8'h15;
    for (int w = 0; w < 2; w++) begin
      bcd_in = words[w]; bcd_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (m_acc) bcd_valid = 1'b0;
        if (w == 0 && err) saw_err = 1;
        if (w == 0 && dig_en == 2'b01 && seg == 7'h40) saw_dash = 1;
        if (w == 1 && dig_en == 2'b01 && seg == 7'h6D && !err) saw_clear = 1;
        n_checks++;
        if (seg !== exp_seg || dig_en !== exp_dig || err !== exp_err || bcd_ready !== !m_pend) begin
          n_fail++;
          $display("[TB] FAIL invalid cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, seg, dig_en, err, bcd_ready, exp_seg, exp_dig, exp_err, !m_pend);
        end
      end
      bcd_valid = 1'b0;
    end
    n_checks++;
    if ({saw_err, saw_dash, saw_clear} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL invalid_flags got=%b exp=111", {saw_err, saw_dash, saw_clear});
    end
  endtask

  task automatic test_reset_mid();
    bit saw_9;
    saw_9 = 0;
    for (int i = 0; i < 12 && !(cyc % (2 * R) == 0 && !m_pend); i++) tick();
    bcd_in = 8'h99; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (seg !== 7'h00 || dig_en !== 2'b00 || err !== 1'b0 || bcd_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mid_reset got=%h/%b/%b/%b exp=00/00/0/1", seg, dig_en, err, bcd_ready);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (seg == 7'h6F) saw_9 = 1;
      n_checks++;
      if (seg !== exp_seg || dig_en !== exp_dig || err !== exp_err || bcd_ready !== !m_pend) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_run cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, seg, dig_en, err, bcd_ready, exp_seg, exp_dig, exp_err, !m_pend);
      end
    end
    n_checks++;
    if (saw_9 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid_nine got=%b exp=0", saw_9); end
  endtask

  task automatic test_leading_zero();
    logic [6:0] tens_seg, ones_seg, want_tens;
`ifdef LEADING_ZERO_BLANK_EN
    want_tens = 7'h00;
`else
    want_tens = 7'h3F;
`endif
    tens_seg = 7'h7F; ones_seg = 7'h7F;
    bcd_in = 8'h05; bcd_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_acc) bcd_valid = 1'b0;
      if (dig_en == 2'b10) tens_seg = seg;
      if (dig_en == 2'b01) ones_seg = seg;
      n_checks++;
      if (seg !== exp_seg || dig_en !== exp_dig || err !== exp_err || bcd_ready !== !m_pend) begin
        n_fail++;
        $display("[TB] FAIL leading_zero cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, seg, dig_en, err, bcd_ready, exp_seg, exp_dig, exp_err, !m_pend);
      end
    end
    bcd_valid = 1'b0;
    n_checks++;
    if (tens_seg !== want_tens) begin n_fail++; $display("[TB] FAIL lz_tens got=%h exp=%h", tens_seg, want_tens); end
    n_checks++;
    if (ones_seg !== 7'h6D) begin n_fail++; $display("[TB] FAIL lz_ones got=%h exp=6d", ones_seg); end
  endtask

  task automatic test_random();
    bcd_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bcd_valid && $urandom_range(0, 3) == 0) begin
        bcd_in    = 8'($urandom);
        bcd_valid = 1'b1;
      end
      tick();
      if (m_acc) bcd_valid = 1'b0;
      n_checks++;
      if (seg !== exp_seg || dig_en !== exp_dig || err !== exp_err || bcd_ready !== !m_pend) begin
        n_fail++;
        $display("[TB] FAIL random cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, seg, dig_en, err, bcd_ready, exp_seg, exp_dig, exp_err, !m_pend);
      end
    end
    bcd_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    test_reset();
    test_accept();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    test_leading_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_seg_display_mux.md
Name: bcd_seg_display_mux

Overview:
Downstream consumer of the 8-bit two-digit BCD code from the binary-to-BCD converter. Captures one BCD word per valid/ready handshake and holds it in a shadow register. Commits the word to the display only at a frame boundary, so a frame never shows a mix of old and new digits. Time-multiplexes the two digits onto a shared 7-segment bus with registered segment and digit-enable outputs.

Parameters:
REFRESH_DIV, 4, clock cycles per digit slot; legal values ≥2; frame period = 2*REFRESH_DIV.
SEG_ACTIVE_LOW, 0, 1 inverts all seg bits at the output (dig_en unaffected).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
bcd_in  input  8  [7:4] tens nibble, [3:0] ones nibble.
bcd_valid  input  1  bcd_in valid.
bcd_ready  output  1  block can accept; equals !pending.
seg  output  7  segments {g,f,e,d,c,b,a}; seg[0]=a; registered.
dig_en  output  2  one-hot digit enable; [0]=ones, [1]=tens; active-high; registered.
err  output  1  high while the displayed word holds a nibble >9; registered.

Behaviour:
- Reset: the clock and reset are fixed as one clock, clk, and reset rst, asynchronous and active-high.
- Reset values: cnt=0, slot=ONES, disp=8'h00, shadow=8'h00, pending=0.
- Reset output values: seg=all segments off (7'h00, or 7'h7F when SEG_ACTIVE_LOW=1), dig_en=2'b00, err=0, bcd_ready=1.
- Reset mid-operation: discards any pending word; no partial commit.
- Handshake: an accept occurs on an edge with bcd_valid && bcd_ready.
  - On accept: shadow<=bcd_in, pending<=1, so bcd_ready is 0 from the next cycle.
  - bcd_in is ignored while pending=1.
  - bcd_valid may stay high; the source holds data until accepted.
- Counter: cnt increments every cycle. At cnt==REFRESH_DIV-1, cnt<=0 and slot toggles.
- Scan state machine, two states:
  - ONES→TENS on a cnt wrap in ONES.
  - TENS→ONES on a cnt wrap in TENS; this edge is the frame boundary.
- Commit: at the frame-boundary edge, if pending=1, disp<=shadow and pending<=0.
  - bcd_ready returns to 1 the cycle after commit.
  - No accept can coincide with a commit, because ready=0 throughout.
- Output register: at each edge, seg/dig_en/err are loaded from the current-cycle slot and disp, giving one cycle of latency.
  - dig_en=2'b01 for ONES, 2'b10 for TENS.
  - First valid dig_en appears on the first edge after rst deasserts.
- Decode (active-high, gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
  - Nibble 10–15 decodes to a dash, 7'h40.
- err: registered as (disp[7:4]>9)||(disp[3:0]>9), so it changes only on commit plus one cycle.
- Width and arithmetic:
  - cnt width = $clog2(REFRESH_DIV).
  - No arithmetic on BCD data; nibbles pass through the decode only.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in the TENS slot, if disp[7:4]==0, seg=all off while dig_en=2'b10 is still asserted. The ones digit is never blanked, so 8'h00 shows a single "0".
- Undefined: the tens digit always decodes normally, so 0 shows as 7'h3F.

Test Plan:
All scenarios use REFRESH_DIV=4, SEG_ACTIVE_LOW=0.
1. Reset: rst high → seg=7'h00, dig_en=2'b00, err=0, bcd_ready=1. After release, 1 edge later dig_en=2'b01, seg=7'h3F; dig_en toggles every 4 cycles.
2. Accept: drive 8'h27 with valid for 1 cycle → bcd_ready=0 next cycle until the next TENS→ONES edge. Afterwards the ONES slot shows seg=7'h07 and the TENS slot shows 7'h5B; bcd_ready=1 the cycle after commit.
3. Back-to-back: 8'h27 accepted, then 8'h31 held with valid while pending → 8'h31 accepted only after ready returns. The frame before that shows 2/7; the following frame shows 3/1 (4F/06). No frame mixes digits.
4. Invalid: accept 8'h1A → after commit, ONES seg=7'h40, TENS seg=7'h06, err=1. Then accept 8'h15 → after the next commit, err=0 and ONES seg=7'h6D.
5. Reset mid-operation: accept 8'h99, assert rst before the frame boundary → after release, display shows 00, bcd_ready=1, no 9s ever appear.
6. Leading zero: accept 8'h05.
   - With LEADING_ZERO_BLANK_EN: TENS slot seg=7'h00, dig_en=2'b10.
   - Without it: TENS slot seg=7'h3F.
   - Both builds: ONES slot seg=7'h6D.
